// File: rtl/curve_param_bank.sv
// Runtime-loadable multi-slot store of elliptic-curve parameter sets, loaded limb by limb.
// Optional macro CURVE_PARAM_RANGE_CHECK_EN: reject a, b, gx, gy values not below the slot's p.

package elliptic_curve_structs;

    localparam int P_WIDTH = 377;

    typedef struct packed {
        logic [P_WIDTH-1:0] p;
        logic [P_WIDTH-1:0] n;
        logic [P_WIDTH-1:0] a;
        logic [P_WIDTH-1:0] b;
        logic [P_WIDTH-1:0] gx;
        logic [P_WIDTH-1:0] gy;
    } curve_parameters_t;

    // BLS12-377 G1
    localparam curve_parameters_t params = '{
        p:  377'h1ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001,
        n:  377'h12ab655e9a2ca55660b44d1e5c37b00159aa76fed00000010a11800000000001,
        a:  377'd0,
        b:  377'd1,
        gx: 377'h8848defe740a67c8fc6225bf87ff5485951e2caa9d41bb188282c8bd37cb5cd5481512ffcd394eeab9b16eb21be9ef,
        gy: 377'h1914a69c5102eff1f674f5d30afeec4bd7fb348ca3e52d96d182ad44fb82305c2fe3d3634a9591afd82de55559c8ea6
    };

endpackage

module curve_param_bank #(
    parameter int P_WIDTH    = elliptic_curve_structs::P_WIDTH,
    parameter int LIMB_W     = 64,
    parameter int NUM_CURVES = 4,
    localparam int SLOT_W    = (NUM_CURVES > 1) ? $clog2(NUM_CURVES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LIMB_W-1:0]      in_limb,
    input  logic [SLOT_W-1:0]      in_slot,
    input  logic [2:0]             in_field,
    input  logic                   in_last,
    output logic                   commit_pulse,
    output logic                   err_pulse,
    output logic [1:0]             err_code,
    input  logic [SLOT_W-1:0]      rd_sel,
    output logic [6*P_WIDTH-1:0]   rd_params,
    output logic                   rd_valid,
    output logic                   busy
);

    localparam int NUM_LIMBS = (P_WIDTH + LIMB_W - 1) / LIMB_W;
    localparam int SH_W      = NUM_LIMBS * LIMB_W;
    localparam int CNT_W     = $clog2(NUM_LIMBS + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_LIMBS - 1);
    localparam logic [SLOT_W:0]   NC_EXT   = (SLOT_W + 1)'(NUM_CURVES);

    localparam logic [1:0] ERR_FIELD = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, COMMIT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SH_W-1:0]     shadow;
    logic [CNT_W-1:0]    cnt;
    logic [SLOT_W-1:0]   slot_q;
    logic [2:0]          field_q;
    logic [1:0]          pend_code;
    logic [P_WIDTH-1:0]  bank [NUM_CURVES][6];
    logic [5:0]          mask [NUM_CURVES];
    logic [6*P_WIDTH-1:0] rd_params_p1;
    logic                vld_p1;

    logic                hs;
    logic                cap_first;
    logic                store_limb;
    logic                set_pend;
    logic [1:0]          pend_nxt;
    logic                fire_err;
    logic [1:0]          err_nxt;
    logic                do_write;
    logic                range_bad;

    function automatic logic [P_WIDTH-1:0] def_field(input int f);
        case (f)
            0:       return P_WIDTH'(elliptic_curve_structs::params.p);
            1:       return P_WIDTH'(elliptic_curve_structs::params.n);
            2:       return P_WIDTH'(elliptic_curve_structs::params.a);
            3:       return P_WIDTH'(elliptic_curve_structs::params.b);
            4:       return P_WIDTH'(elliptic_curve_structs::params.gx);
            default: return P_WIDTH'(elliptic_curve_structs::params.gy);
        endcase
    endfunction

    function automatic logic overflow(input logic [SH_W-1:0] s);
        return (s >> P_WIDTH) != '0;
    endfunction

    function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
        return {1'b0, s} < NC_EXT;
    endfunction

    assign in_ready = (state != COMMIT);
    assign busy     = (state != IDLE);
    assign hs       = in_valid && (state != COMMIT);

`ifdef CURVE_PARAM_RANGE_CHECK_EN
    // Only meaningful in COMMIT, where field_q is always a legal 0..5 index.
    assign range_bad = (field_q >= 3'd2) && mask[slot_q][0] &&
                       (shadow[P_WIDTH-1:0] >= bank[slot_q][0]);
`else
    assign range_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cap_first  = 1'b0;
        store_limb = 1'b0;
        set_pend   = 1'b0;
        pend_nxt   = pend_code;
        fire_err   = 1'b0;
        err_nxt    = err_code;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    cap_first = 1'b1;
                    // A slot index beyond NUM_CURVES is rejected like an unknown field.
                    if (in_field > 3'd5 || !slot_ok(in_slot)) begin
                        if (in_last) begin
                            fire_err = 1'b1;
                            err_nxt  = ERR_FIELD;
                        end else begin
                            state_nxt = DRAIN;
                            set_pend  = 1'b1;
                            pend_nxt  = ERR_FIELD;
                        end
                    end else if (NUM_LIMBS == 1) begin
                        if (in_last) begin
                            state_nxt = COMMIT;
                        end else begin
                            state_nxt = DRAIN;
                            set_pend  = 1'b1;
                            pend_nxt  = ERR_LEN;
                        end
                    end else if (in_last) begin
                        fire_err = 1'b1;
                        err_nxt  = ERR_LEN;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (hs) begin
                    store_limb = 1'b1;
                    if (cnt == LAST_IDX) begin
                        if (in_last) begin
                            state_nxt = COMMIT;
                        end else begin
                            state_nxt = DRAIN;
                            set_pend  = 1'b1;
                            pend_nxt  = ERR_LEN;
                        end
                    end else if (in_last) begin
                        fire_err  = 1'b1;
                        err_nxt   = ERR_LEN;
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (hs && in_last) begin
                    fire_err  = 1'b1;
                    err_nxt   = pend_code;
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                if (overflow(shadow)) begin
                    fire_err = 1'b1;
                    err_nxt  = ERR_OVF;
                end else if (range_bad) begin
                    fire_err = 1'b1;
                    err_nxt  = ERR_RANGE;
                end else begin
                    do_write = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Limb collection, bank update and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow       <= '0;
            cnt          <= '0;
            slot_q       <= '0;
            field_q      <= '0;
            pend_code    <= '0;
            commit_pulse <= 1'b0;
            err_pulse    <= 1'b0;
            err_code     <= '0;
            for (int c = 0; c < NUM_CURVES; c++) begin
                mask[c] <= (c == 0) ? 6'b111111 : 6'b000000;
                for (int f = 0; f < 6; f++) begin
                    bank[c][f] <= (c == 0) ? def_field(f) : '0;
                end
            end
        end else begin
            commit_pulse <= do_write;
            err_pulse    <= fire_err;
            if (fire_err) err_code <= err_nxt;
            if (set_pend) pend_code <= pend_nxt;
            if (cap_first) begin
                slot_q  <= in_slot;
                field_q <= in_field;
                shadow  <= SH_W'(in_limb);
                cnt     <= CNT_W'(1);
            end else if (store_limb) begin
                shadow[cnt*LIMB_W +: LIMB_W] <= in_limb;
                cnt <= cnt + 1'b1;
            end
            if (do_write) begin
                bank[slot_q][field_q] <= shadow[P_WIDTH-1:0];
                mask[slot_q][field_q] <= 1'b1;
            end
        end
    end

    // Read stage p1: registered slot lookup
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_params_p1 <= {def_field(0), def_field(1), def_field(2),
                             def_field(3), def_field(4), def_field(5)};
            vld_p1       <= 1'b1;
        end else if (slot_ok(rd_sel)) begin
            rd_params_p1 <= {bank[rd_sel][0], bank[rd_sel][1], bank[rd_sel][2],
                             bank[rd_sel][3], bank[rd_sel][4], bank[rd_sel][5]};
            vld_p1       <= &mask[rd_sel];
        end else begin
            rd_params_p1 <= '0;
            vld_p1       <= 1'b0;
        end
    end

    assign rd_params = rd_params_p1;
    assign rd_valid  = vld_p1;

endmodule
